// File: rtl/audio_pkg.sv
// Shared definitions for the audio PWM output stage.
package audio_pkg;

  // Default PWM resolution in bits.
  localparam int PWM_BITS_DEF = 8;

  // Silence level for an unsigned sample of a given width: 2^(bits-1).
  function automatic int unsigned midpoint(input int bits);
    return 32'd1 << (bits - 1);
  endfunction

  // Silence level at the default resolution.
  localparam logic [PWM_BITS_DEF-1:0] MIDPOINT = PWM_BITS_DEF'(midpoint(PWM_BITS_DEF));

  // Output stage operating state.
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/audio_fifo.sv
// Synchronous sample FIFO with flush.
// Pointers carry one extra wrap bit so full and empty can be told apart.
// A pop on an empty FIFO is ignored; there is no write-to-read bypass.
module audio_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = PWM_BITS_DEF,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign o_level = wptr_q - rptr_q;
  assign o_data  = mem[rptr_q[AW-1:0]];

  assign do_push = i_push && !o_full  && !i_flush;
  assign do_pop  = i_pop  && !o_empty && !i_flush;

  // Sample storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wptr_q[AW-1:0]] <= i_data;
    end
  end

  // Read/write pointers; a flush empties the FIFO in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (i_flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/audio_pwm_out.sv
// Audio output stage: buffers PCM samples, fetches one per sample period and
// drives a single-bit PWM stream plus the amplifier enable pin.
// Disabling lets the current PWM period finish before the amplifier turns off.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int SAMPLE_DIV = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic [PWM_BITS-1:0]           i_sample,
  input  logic                          i_sample_valid,
  output logic                          o_sample_ready,
  input  logic                          i_clr_underrun,
  output logic                          o_pwm_audio,
  output logic                          o_sd_audio,
  output logic                          o_underrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam logic [PWM_BITS-1:0] MID      = PWM_BITS'(midpoint(PWM_BITS));
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam int                  PER_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PER_W-1:0]    PER_LAST = PER_W'(SAMPLE_DIV - 1);

  state_e              state_q;
  state_e              state_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PER_W-1:0]    per_cnt_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] fifo_data;
  logic                pwm_q;
  logic                underrun_q;
  logic                pwm_active;
  logic                wrap;
  logic                tick;
  logic                push;
  logic                pop;
  logic                flush;
  logic                run_ready;
  logic                fifo_full;
  logic                fifo_empty;

  // Wrap marks the last clock of a PWM period; a tick is the wrap that ends
  // a sample period. Samples are only fetched while running, not draining.
  assign pwm_active = (state_q != OFF);
  assign wrap       = pwm_active && (pwm_cnt_q == CNT_MAX);
  assign tick       = (state_q == RUN) && wrap && (per_cnt_q == PER_LAST);
  assign pop        = tick && !fifo_empty;
  assign push       = i_sample_valid && o_sample_ready;

  assign o_sample_ready = run_ready && !fifo_full;
  assign o_pwm_audio    = pwm_q;
  assign o_underrun     = underrun_q;

  audio_fifo #(
    .WIDTH (PWM_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (i_sample),
    .i_pop   (pop),
    .i_flush (flush),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_fifo_level)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= OFF;
    else          state_q <= state_d;
  end

  // Next state and state-decoded controls; the FIFO is flushed while off and
  // on the cycle that enters OFF so the level reads zero immediately.
  always_comb begin
    state_d    = state_q;
    run_ready  = 1'b0;
    o_sd_audio = 1'b0;
    flush      = 1'b0;
    case (state_q)
      OFF: begin
        flush = 1'b1;
        if (i_enable) state_d = RUN;
      end
      RUN: begin
        o_sd_audio = 1'b1;
        run_ready  = 1'b1;
        if (!i_enable) state_d = DRAIN;
      end
      DRAIN: begin
        o_sd_audio = 1'b1;
        if (wrap) begin
          state_d = OFF;
          flush   = 1'b1;
        end
      end
      default: begin
        state_d = OFF;
        flush   = 1'b1;
      end
    endcase
  end

  // PWM and sample-period counters; held at zero while off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_cnt_q <= '0;
      per_cnt_q <= '0;
    end else if (!pwm_active) begin
      pwm_cnt_q <= '0;
      per_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (wrap) per_cnt_q <= (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + PER_W'(1);
    end
  end

  // Duty only changes at a tick (last clock of a period), so every PWM period
  // uses one duty value; it starts at silence whenever the stage is off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           duty_q <= MID;
    else if (!pwm_active)   duty_q <= MID;
    else if (pop)           duty_q <= fifo_data;
  end

  // Registered PWM comparator output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         pwm_q <= 1'b0;
    else if (!pwm_active) pwm_q <= 1'b0;
    else                  pwm_q <= (pwm_cnt_q < duty_q);
  end

  // Sticky underrun flag; a new underrun wins over a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                underrun_q <= 1'b0;
    else if (tick && fifo_empty) underrun_q <= 1'b1;
    else if (i_clr_underrun)     underrun_q <= 1'b0;
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Bench for audio_pwm_out: directed scenarios plus randomized traffic, with a
// time-based reference model compared against the DUT every clock.
module tb_audio_pwm_out;

  localparam int FD  = 16;
  localparam int SD  = 4;
  localparam int PER = 256;
  localparam int MID = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] sample;
  logic       valid;
  logic       clr;
  logic       o_sample_ready;
  logic       o_pwm_audio;
  logic       o_sd_audio;
  logic       o_underrun;
  logic [4:0] o_fifo_level;

  int n_chk = 0;
  int n_err = 0;

  audio_pwm_out #(
    .PWM_BITS   (8),
    .SAMPLE_DIV (SD),
    .FIFO_DEPTH (FD)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_sample       (sample),
    .i_sample_valid (valid),
    .o_sample_ready (o_sample_ready),
    .i_clr_underrun (clr),
    .o_pwm_audio    (o_pwm_audio),
    .o_sd_audio     (o_sd_audio),
    .o_underrun     (o_underrun),
    .o_fifo_level   (o_fifo_level)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: m_t counts clocks since the stage started running, so
  // the PWM phase is m_t % 256 and the PWM period index is m_t / 256.
  bit         m_on, m_run, m_pwm, m_under;
  int         m_t, m_duty, m_ophase, m_operiod;
  logic [7:0] q[$];
  bit         mb_push, mb_empty, mb_tick;
  int         m_phase;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 0; m_run = 0; m_pwm = 0; m_under = 0;
      m_t = 0; m_duty = MID; m_ophase = 0; m_operiod = -1;
      q.delete();
    end else begin
      mb_push  = valid && m_run && (q.size() < FD);
      mb_empty = (q.size() == 0);
      mb_tick  = 0;
      if (!m_on) begin
        m_pwm = 0;
        m_operiod = -1;
        if (enable) begin
          m_on = 1; m_run = 1; m_t = 0; m_duty = MID;
        end
      end else begin
        m_phase   = m_t % PER;
        m_ophase  = m_phase;
        m_operiod = m_t / PER;
        m_pwm     = (m_phase < m_duty);
        mb_tick   = m_run && (m_phase == PER - 1) && ((m_t / PER) % SD == SD - 1);
        if (mb_tick && !mb_empty) m_duty = int'(q.pop_front());
        if (mb_push) q.push_back(sample);
        if (!m_run && m_phase == PER - 1) begin
          m_on = 0; q.delete(); m_duty = MID;
        end else if (m_run && !enable) begin
          m_run = 0;
        end
        m_t++;
      end
      if (mb_tick && mb_empty) m_under = 1;
      else if (clr)            m_under = 0;
    end
  end

  // Every clock, compare all outputs with the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("cyc_pwm",   int'(o_pwm_audio),    int'(m_pwm));
      check_eq("cyc_sd",    int'(o_sd_audio),     int'(m_on));
      check_eq("cyc_ready", int'(o_sample_ready), (m_run && q.size() < FD) ? 1 : 0);
      check_eq("cyc_under", int'(o_underrun),     int'(m_under));
      check_eq("cyc_level", int'(o_fifo_level),   q.size());
    end
  end

  task automatic wait_t(input int target);
    bit found = 0;
    for (int i = 0; i < 6000; i++) begin
      if (m_on && m_t == target) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("wait_t", int'(found), 1);
  endtask

  // Count high clocks of o_pwm_audio over output PWM period p.
  task automatic measure(input int p, output int n);
    bit found = 0;
    n = 0;
    for (int i = 0; i < 6000; i++) begin
      if (m_on && m_operiod == p && m_ophase == 0) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("meas_sync", int'(found), 1);
    for (int i = 0; i < PER; i++) begin
      n += int'(o_pwm_audio);
      @(negedge clk);
    end
  endtask

  task automatic push(input logic [7:0] v);
    bit found = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_sample_ready) begin
        valid = 1; sample = v;
        @(negedge clk);
        valid = 0;
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("push_rdy", int'(found), 1);
  endtask

  task automatic go_off();
    bit found = 0;
    enable = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!o_sd_audio) begin
        found = 1;
        break;
      end
    end
    check_eq("off_reached", int'(found), 1);
    check_eq("off_level", int'(o_fifo_level), 0);
  endtask

  task automatic pulse_clr();
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, rdy_seen;
    rst_n = 0; enable = 0; valid = 0; sample = 8'h00; clr = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_pwm",   int'(o_pwm_audio),    0);
    check_eq("rst_sd",    int'(o_sd_audio),     0);
    check_eq("rst_ready", int'(o_sample_ready), 0);
    check_eq("rst_under", int'(o_underrun),     0);
    check_eq("rst_level", int'(o_fifo_level),   0);
    rst_n = 1;
    @(negedge clk);

    // Enable with no samples: silence, then underrun at the first tick.
    enable = 1;
    @(negedge clk);
    check_eq("s1_sd",    int'(o_sd_audio),     1);
    check_eq("s1_ready", int'(o_sample_ready), 1);
    measure(0, n);
    check_eq("s1_mid_high", n, MID);
    wait_t(1000);
    check_eq("s1_no_under", int'(o_underrun), 0);
    wait_t(1030);
    check_eq("s1_under", int'(o_underrun), 1);
    go_off();

    // Three samples show up in successive sample periods.
    pulse_clr();
    enable = 1;
    @(negedge clk);
    push(8'h00); push(8'hFF); push(8'h40);
    measure(4, n);  check_eq("s2_duty00", n, 0);
    measure(8, n);  check_eq("s2_dutyFF", n, 255);
    measure(12, n); check_eq("s2_duty40", n, 64);
    go_off();

    // Keep valid high: FIFO fills to 16, ready drops, pops stay in order.
    pulse_clr();
    enable = 1;
    @(negedge clk);
    valid = 1;
    for (int i = 0; i < 40; i++) begin
      sample = 8'($urandom);
      @(negedge clk);
    end
    check_eq("s3_full_level", int'(o_fifo_level), FD);
    check_eq("s3_full_ready", int'(o_sample_ready), 0);
    for (int i = 0; i < 3300; i++) begin
      sample = 8'($urandom);
      @(negedge clk);
    end
    check_eq("s3_level_end", int'(o_fifo_level), FD);
    valid = 0;
    go_off();

    // Push on the tick into an empty FIFO: underrun, previous duty held.
    pulse_clr();
    enable = 1;
    @(negedge clk);
    wait_t(1023);
    check_eq("s4_ready", int'(o_sample_ready), 1);
    valid = 1; sample = 8'h10;
    @(negedge clk);
    valid = 0;
    check_eq("s4_under_set", int'(o_underrun), 1);
    check_eq("s4_level", int'(o_fifo_level), 1);
    measure(4, n);  check_eq("s4_duty_held", n, MID);
    measure(8, n);  check_eq("s4_duty10", n, 16);
    wait_t(2500);
    pulse_clr();
    check_eq("s4_cleared", int'(o_underrun), 0);
    wait_t(3071);
    pulse_clr();
    check_eq("s4_set_beats_clr", int'(o_underrun), 1);
    measure(12, n); check_eq("s4_duty_held2", n, 16);
    go_off();

    // Drop enable mid-period: amplifier stays on until the wrap.
    pulse_clr();
    enable = 1;
    @(negedge clk);
    push(8'h20); push(8'h30);
    wait_t(300);
    enable = 0;
    @(negedge clk);
    check_eq("s5_ready_low", int'(o_sample_ready), 0);
    cnt = 0; rdy_seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (!o_sd_audio) break;
      cnt++;
      rdy_seen += int'(o_sample_ready);
      @(negedge clk);
    end
    check_eq("s5_sd_hold", cnt, 211);
    check_eq("s5_ready_seen", rdy_seen, 0);
    check_eq("s5_flushed", int'(o_fifo_level), 0);

    // Asynchronous reset mid-run with five samples buffered.
    enable = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    wait_t(100);
    check_eq("s6_level5", int'(o_fifo_level), 5);
    check_eq("s6_pwm_pre", int'(o_pwm_audio), 1);
    @(posedge clk);
    #3;
    rst_n = 0; enable = 0;
    #1;
    check_eq("s6_rst_pwm",   int'(o_pwm_audio),    0);
    check_eq("s6_rst_sd",    int'(o_sd_audio),     0);
    check_eq("s6_rst_ready", int'(o_sample_ready), 0);
    check_eq("s6_rst_level", int'(o_fifo_level),   0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_eq("s6_post_level", int'(o_fifo_level), 0);
    enable = 1;
    @(negedge clk);
    measure(0, n);
    check_eq("s6_mid_high", n, MID);
    go_off();

    // Randomized traffic, enables and clears.
    pulse_clr();
    enable = 1;
    for (int i = 0; i < 9000; i++) begin
      valid  = ($urandom_range(0, 699) == 0);
      sample = 8'($urandom);
      clr    = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1999) == 0) enable = !enable;
      @(negedge clk);
    end
    valid = 0; clr = 0;
    go_off();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
